// File: rtl/sprite_spi_regfile.sv
// SPI-loaded multi-sprite register file: 24-bit frames {idx[2:0], field[4:0], data[15:0]}.
// Define SPRITE_SPI_FRAME_LATCH_EN to stage commits in shadows copied out on frame_sync.
module sprite_spi_regfile #(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned SPRITE_W    = 8,
  parameter int unsigned SPRITE_H    = 8,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned COLOR_W     = 6,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    spi_clk,
  input  logic                                    spi_data,
  input  logic                                    frame_sync,
  output logic [NUM_SPRITES*COORD_W-1:0]          sprite_x,
  output logic [NUM_SPRITES*COORD_W-1:0]          sprite_y,
  output logic [NUM_SPRITES*COLOR_W-1:0]          sprite_color,
  output logic [NUM_SPRITES*SPRITE_H*SPRITE_W-1:0] sprite_bitmap,
  output logic                                    wr_pulse,
  output logic                                    err_pulse,
  output logic                                    busy
);

  localparam int unsigned TW         = $clog2(TIMEOUT + 1);
  localparam int unsigned NUM_FIELDS = 3 + SPRITE_H;

  logic          spi_clk_s1, spi_clk_s2, spi_clk_prev;
  logic          spi_data_s1, spi_data_s2;
  logic          spi_edge;
  logic [23:0]   shift_q;
  logic [4:0]    bit_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic          commit, valid, timed_out;
  logic [2:0]    idx;
  logic [4:0]    field;
  logic [15:0]   data;

  assign spi_edge  = spi_clk_s2 & ~spi_clk_prev;
  // bit_cnt_q == 24 marks the commit cycle that follows the final edge
  assign commit    = (bit_cnt_q == 5'd24);
  assign timed_out = (to_cnt_q == TW'(TIMEOUT));
  assign idx       = shift_q[23:21];
  assign field     = shift_q[20:16];
  assign data      = shift_q[15:0];
  assign valid     = (32'(idx) < NUM_SPRITES) && (32'(field) < NUM_FIELDS);
  assign busy      = (bit_cnt_q != 5'd0);

  logic unused_data;
  assign unused_data = ^data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spi_clk_s1   <= 1'b0;
      spi_clk_s2   <= 1'b0;
      spi_clk_prev <= 1'b0;
      spi_data_s1  <= 1'b0;
      spi_data_s2  <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      wr_pulse     <= 1'b0;
      err_pulse    <= 1'b0;
    end else begin
      spi_clk_s1   <= spi_clk;
      spi_clk_s2   <= spi_clk_s1;
      spi_clk_prev <= spi_clk_s2;
      spi_data_s1  <= spi_data;
      spi_data_s2  <= spi_data_s1;
      wr_pulse     <= commit & valid;
      err_pulse    <= commit & ~valid;
      if (spi_edge) begin
        // an edge during the commit cycle becomes bit 1 of the next frame
        shift_q   <= {shift_q[22:0], spi_data_s2};
        bit_cnt_q <= commit ? 5'd1 : bit_cnt_q + 5'd1;
        to_cnt_q  <= '0;
      end else begin
        if (!timed_out) to_cnt_q <= to_cnt_q + 1'b1;
        if (commit || timed_out) bit_cnt_q <= '0;
      end
    end
  end

  // Commit-target registers: shadows when latching, the live outputs otherwise
  logic [COORD_W-1:0]  x_q   [NUM_SPRITES];
  logic [COORD_W-1:0]  y_q   [NUM_SPRITES];
  logic [COLOR_W-1:0]  col_q [NUM_SPRITES];
  logic [SPRITE_W-1:0] bmp_q [NUM_SPRITES][SPRITE_H];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        col_q[i] <= '0;
        for (int r = 0; r < SPRITE_H; r++) bmp_q[i][r] <= '0;
      end
    end else if (commit && valid) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (idx == 3'(i)) begin
          if (field == 5'd0) x_q[i]   <= data[COORD_W-1:0];
          if (field == 5'd1) y_q[i]   <= data[COORD_W-1:0];
          if (field == 5'd2) col_q[i] <= data[COLOR_W-1:0];
          for (int r = 0; r < SPRITE_H; r++) begin
            if (field == 5'(r + 3)) bmp_q[i][r] <= data[SPRITE_W-1:0];
          end
        end
      end
    end
  end

  logic [COORD_W-1:0]  x_vis   [NUM_SPRITES];
  logic [COORD_W-1:0]  y_vis   [NUM_SPRITES];
  logic [COLOR_W-1:0]  col_vis [NUM_SPRITES];
  logic [SPRITE_W-1:0] bmp_vis [NUM_SPRITES][SPRITE_H];

`ifdef SPRITE_SPI_FRAME_LATCH_EN
  logic [COORD_W-1:0]  x_out_q   [NUM_SPRITES];
  logic [COORD_W-1:0]  y_out_q   [NUM_SPRITES];
  logic [COLOR_W-1:0]  col_out_q [NUM_SPRITES];
  logic [SPRITE_W-1:0] bmp_out_q [NUM_SPRITES][SPRITE_H];

  // Copy sees pre-commit shadow values, so a coincident commit waits a frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_out_q[i]   <= '0;
        y_out_q[i]   <= '0;
        col_out_q[i] <= '0;
        for (int r = 0; r < SPRITE_H; r++) bmp_out_q[i][r] <= '0;
      end
    end else if (frame_sync) begin
      x_out_q   <= x_q;
      y_out_q   <= y_q;
      col_out_q <= col_q;
      bmp_out_q <= bmp_q;
    end
  end

  assign x_vis   = x_out_q;
  assign y_vis   = y_out_q;
  assign col_vis = col_out_q;
  assign bmp_vis = bmp_out_q;
`else
  logic unused_frame_sync;
  assign unused_frame_sync = frame_sync;

  assign x_vis   = x_q;
  assign y_vis   = y_q;
  assign col_vis = col_q;
  assign bmp_vis = bmp_q;
`endif

  always_comb begin
    sprite_x      = '0;
    sprite_y      = '0;
    sprite_color  = '0;
    sprite_bitmap = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      sprite_x[i*COORD_W +: COORD_W]     = x_vis[i];
      sprite_y[i*COORD_W +: COORD_W]     = y_vis[i];
      sprite_color[i*COLOR_W +: COLOR_W] = col_vis[i];
      for (int r = 0; r < SPRITE_H; r++) begin
        sprite_bitmap[(i*SPRITE_H + r)*SPRITE_W +: SPRITE_W] = bmp_vis[i][r];
      end
    end
  end

endmodule

// File: tb/tb_sprite_spi_regfile.sv
// Randomized self-checking bench for sprite_spi_regfile against a field-level array model.
module tb_sprite_spi_regfile;

  localparam int NS = 4;
  localparam int SW = 8;
  localparam int SH = 8;
  localparam int CW = 10;
  localparam int KW = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spi_clk = 1'b0;
  logic spi_data = 1'b0;
  logic frame_sync = 1'b0;
  logic [NS*CW-1:0]    sprite_x, sprite_y;
  logic [NS*KW-1:0]    sprite_color;
  logic [NS*SH*SW-1:0] sprite_bitmap;
  logic wr_pulse, err_pulse, busy;

  sprite_spi_regfile dut (
    .clk          (clk),
    .reset        (reset),
    .spi_clk      (spi_clk),
    .spi_data     (spi_data),
    .frame_sync   (frame_sync),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .sprite_color (sprite_color),
    .sprite_bitmap(sprite_bitmap),
    .wr_pulse     (wr_pulse),
    .err_pulse    (err_pulse),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, err_cnt = 0, wide_cnt = 0;
  logic wr_prev = 1'b0, err_prev = 1'b0;

  // Shadow model (what commits write) and visible model (what outputs show)
  logic [CW-1:0] sh_x [NS], sh_y [NS], vis_x [NS], vis_y [NS];
  logic [KW-1:0] sh_c [NS], vis_c [NS];
  logic [SW-1:0] sh_b [NS][SH], vis_b [NS][SH];

  always @(negedge clk) begin
    if (wr_pulse) wr_cnt++;
    if (err_pulse) err_cnt++;
    if ((wr_pulse && wr_prev) || (err_pulse && err_prev)) wide_cnt++;
    wr_prev  = wr_pulse;
    err_prev = err_pulse;
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      sh_x[i] = '0; sh_y[i] = '0; sh_c[i] = '0;
      vis_x[i] = '0; vis_y[i] = '0; vis_c[i] = '0;
      for (int r = 0; r < SH; r++) begin
        sh_b[i][r] = '0;
        vis_b[i][r] = '0;
      end
    end
  endtask

  task automatic model_copy();
    vis_x = sh_x; vis_y = sh_y; vis_c = sh_c; vis_b = sh_b;
  endtask

  task automatic model_write(input logic [23:0] f, output bit ok);
    int idx, field;
    logic [15:0] d;
    idx = int'(f[23:21]);
    field = int'(f[20:16]);
    d = f[15:0];
    ok = (idx < NS) && (field < 3 + SH);
    if (ok) begin
      if (field == 0) sh_x[idx] = d[CW-1:0];
      else if (field == 1) sh_y[idx] = d[CW-1:0];
      else if (field == 2) sh_c[idx] = d[KW-1:0];
      else sh_b[idx][field-3] = d[SW-1:0];
    end
`ifndef SPRITE_SPI_FRAME_LATCH_EN
    model_copy();
`endif
  endtask

  task automatic check_outputs(input string tag);
    logic [511:0] ex, ey, ec, eb;
    ex = '0; ey = '0; ec = '0; eb = '0;
    for (int i = 0; i < NS; i++) begin
      ex[i*CW +: CW] = vis_x[i];
      ey[i*CW +: CW] = vis_y[i];
      ec[i*KW +: KW] = vis_c[i];
      for (int r = 0; r < SH; r++) eb[(i*SH + r)*SW +: SW] = vis_b[i][r];
    end
    check({tag, ".x"}, 512'(sprite_x), ex);
    check({tag, ".y"}, 512'(sprite_y), ey);
    check({tag, ".color"}, 512'(sprite_color), ec);
    check({tag, ".bitmap"}, 512'(sprite_bitmap), eb);
    check({tag, ".busy"}, 512'(busy), 512'(0));
  endtask

  task automatic send_bits(input logic [23:0] f, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      spi_data = f[23-i];
      spi_clk = 1'b0;
      repeat (half) @(posedge clk);
      #1;
      spi_clk = 1'b1;
      repeat (half) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    @(posedge clk);
    #1;
    frame_sync = 1'b0;
`ifdef SPRITE_SPI_FRAME_LATCH_EN
    model_copy();
`endif
  endtask

  task automatic do_frame(input string tag, input logic [23:0] f, input int half);
    int wr0, err0;
    bit ok;
    wr0 = wr_cnt;
    err0 = err_cnt;
    send_bits(f, 24, half);
    repeat (6) @(posedge clk);
    #1;
    model_write(f, ok);
    check({tag, ".wr_pulses"}, 512'(wr_cnt - wr0), ok ? 512'(1) : 512'(0));
    check({tag, ".err_pulses"}, 512'(err_cnt - err0), ok ? 512'(0) : 512'(1));
    check_outputs(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr0, err0;
    logic [23:0] f;
    model_clear();

    // Reset held: SPI activity must not leak through
    repeat (2) @(posedge clk);
    #1;
    send_bits(24'hFFFFFF, 24, 2);
    spi_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_outputs("in_reset");
    check("in_reset.wr", 512'(wr_cnt), 512'(0));
    check("in_reset.err", 512'(err_cnt), 512'(0));
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check_outputs("idle");

    do_frame("write_x", 24'h000155, 4);
    check("write_x.value", 512'(sprite_x[CW-1:0]), 512'(10'h155));
    do_frame("bitmap", 24'h6500A5, 4);
    check("bitmap.row", 512'(sprite_bitmap[(3*SH + 2)*SW +: SW]), 512'(8'hA5));
    do_frame("color", 24'h62FFFF, 4);
    check("color.value", 512'(sprite_color[3*KW +: KW]), 512'(6'h3F));
    do_frame("bad_idx", 24'h800000, 4);
    do_frame("bad_field", 24'h0B1234, 4);

    // Partial frame dropped by timeout, silently
    wr0 = wr_cnt;
    err0 = err_cnt;
    send_bits(24'hABCDEF, 10, 4);
    repeat (20) @(posedge clk);
    #1;
    check("timeout.busy_mid", 512'(busy), 512'(1));
    spi_clk = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("timeout.busy_after", 512'(busy), 512'(0));
    check("timeout.no_pulse", 512'((wr_cnt - wr0) + (err_cnt - err0)), 512'(0));
    do_frame("after_timeout", 24'h200123, 4);

    // Randomized frames, including out-of-range sprite/field and idle frame_syncs
    for (int n = 0; n < 60; n++) begin
      f = {3'($urandom_range(0, 5)), 5'($urandom_range(0, 12)), 16'($urandom)};
      do_frame("rand", f, $urandom_range(2, 5));
      if ($urandom_range(0, 3) == 0) begin
        pulse_sync();
        check_outputs("rand_sync");
      end
    end

`ifdef SPRITE_SPI_FRAME_LATCH_EN
    pulse_sync();
    do_frame("latch_x", 24'h0000AA, 4);
    pulse_sync();
    check_outputs("latch_x_sync");
    // Final edge timed so the commit cycle coincides with frame_sync
    f = 24'h010077;
    send_bits(f, 23, 4);
    spi_data = f[0];
    spi_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    spi_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pulse_sync();
    begin
      bit ok;
      model_write(f, ok);
    end
    repeat (4) @(posedge clk);
    #1;
    check_outputs("coincide");
    pulse_sync();
    check_outputs("coincide_next");
`endif

    // Reset mid-frame clears everything
    send_bits(24'h3FFFFF, 12, 4);
    spi_clk = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    check_outputs("mid_reset");
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_outputs("post_reset");
    do_frame("post_reset_wr", 24'h41007E, 3);

    check("pulse_width", 512'(wide_cnt), 512'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
